hex_scan_display: RTL

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/hex_scan_pkg.sv | 17 +
 rtl/hex_scan_next.sv | 34 +++
 rtl/hex_scan_display.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the multiplexed hex digit scanner.
package hex_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_e;

  // Ceiling log2 for elaboration-time widths; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hex_scan_next.sv
// Finds the next eligible digit above cur, searching modulo DIGITS.
module hex_scan_next
  import hex_scan_pkg::*;
#(
  parameter  int DIGITS = 8,
  localparam int SELW   = clog2(DIGITS)
) (
  input  logic [SELW-1:0]   cur,
  input  logic [DIGITS-1:0] mask,
  output logic [SELW-1:0]   nxt,
  output logic              wrap,
  output logic              none
);

  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    nxt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= DIGITS; k++) begin
      idx = SELW'((int'(cur) + k) % DIGITS);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  // A lone eligible digit finds itself, which counts as a wrap.
  assign wrap = (nxt <= cur);
  assign none = ~|mask;

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display scanner with frame-atomic data updates.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_display
  import hex_scan_pkg::*;
#(
  parameter  int DIGITS = 8,
  parameter  int DIV    = 10000,
  localparam int SELW   = clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [SELW-1:0]       sel,
  output logic [3:0]            hexdata,
  output logic                  on,
  output logic                  frame_done
);

  localparam int CNTW = clog2(DIV);

  scan_state_e           state, state_nx;
  logic [CNTW-1:0]       cnt;
  logic                  tick;
  logic [4*DIGITS-1:0]   pend_data, pend_data_nx, act_data, act_data_nx, new_data;
  logic [DIGITS-1:0]     pend_en, pend_en_nx, act_en, act_en_nx, new_en;
  logic [DIGITS-1:0]     elig_act, elig_new;
  logic [SELW-1:0]       adv_idx, new_first, sel_nx;
  logic                  adv_wrap, adv_none, new_none, frame_wrap;
  logic [3:0]            hexdata_nx;
  logic                  on_nx, frame_done_nx;

  function automatic logic [SELW-1:0] lowest(input logic [DIGITS-1:0] m);
    lowest = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      if (m[i]) lowest = SELW'(i);
  endfunction

`ifdef HEX_SCAN_LZB_EN
  // Digits above the most significant nonzero nibble are blanked; digit 0 never is.
  function automatic logic [DIGITS-1:0] lzb_keep(input logic [4*DIGITS-1:0] d);
    logic seen;
    seen        = 1'b0;
    lzb_keep    = '0;
    lzb_keep[0] = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (d[4*i +: 4] != 4'h0) seen = 1'b1;
      lzb_keep[i] = seen;
    end
  endfunction

  assign elig_act = act_en & lzb_keep(act_data);
  assign elig_new = new_en & lzb_keep(new_data);
`else
  assign elig_act = act_en;
  assign elig_new = new_en;
`endif

  assign tick = (cnt == CNTW'(DIV - 1));

  // A load landing on the frame boundary goes straight into the new frame.
  assign new_data  = load ? data     : pend_data;
  assign new_en    = load ? digit_en : pend_en;
  assign new_first = lowest(elig_new);
  assign new_none  = ~|elig_new;

  hex_scan_next #(.DIGITS(DIGITS)) u_next (
    .cur  (sel),
    .mask (elig_act),
    .nxt  (adv_idx),
    .wrap (adv_wrap),
    .none (adv_none)
  );

  assign frame_wrap = (state == BLANK) || adv_wrap || adv_none;

  always_comb begin
    state_nx      = state;
    sel_nx        = sel;
    hexdata_nx    = hexdata;
    on_nx         = on;
    frame_done_nx = 1'b0;
    pend_data_nx  = pend_data;
    pend_en_nx    = pend_en;
    act_data_nx   = act_data;
    act_en_nx     = act_en;
    if (load) begin
      pend_data_nx = data;
      pend_en_nx   = digit_en;
    end
    if (tick) begin
      if (frame_wrap) begin
        act_data_nx = new_data;
        act_en_nx   = new_en;
        if (new_none) begin
          state_nx   = BLANK;
          sel_nx     = '0;
          hexdata_nx = 4'h0;
          on_nx      = 1'b0;
        end else begin
          state_nx      = SCAN;
          sel_nx        = new_first;
          hexdata_nx    = new_data[4*new_first +: 4];
          on_nx         = 1'b1;
          frame_done_nx = (state == SCAN);
        end
      end else begin
        sel_nx     = adv_idx;
        hexdata_nx = act_data[4*adv_idx +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      sel        <= '0;
      hexdata    <= 4'h0;
      on         <= 1'b0;
      frame_done <= 1'b0;
      pend_data  <= '0;
      act_data   <= '0;
      pend_en    <= '1;
      act_en     <= '1;
    end else begin
      state      <= state_nx;
      cnt        <= tick ? '0 : cnt + 1'b1;
      sel        <= sel_nx;
      hexdata    <= hexdata_nx;
      on         <= on_nx;
      frame_done <= frame_done_nx;
      pend_data  <= pend_data_nx;
      act_data   <= act_data_nx;
      pend_en    <= pend_en_nx;
      act_en     <= act_en_nx;
    end
  end

endmodule
